approx_mult_sched: RTL and testbench

Round-robin scheduler that shares one `approx_mult` floating-point multiplier core among `N_REQ` requesters.
- Each requester hands over a 32-bit operand pair over a valid/ready handshake.
- The block issues at most one pair per cycle into the core.
- It tags each pair with the requester index and returns results in issue order through a credit-protected response FIFO with downstream backpressure.
- It sits between the accelerator's operand producers and its result consumer. It is the only owner of the multiplier instance.

---
 rtl/approx_mult_pkg.sv | 23 ++
 rtl/approx_mult.sv | 57 +++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/approx_mult_sched.sv | 146 ++++++++++++++
 tb/tb_approx_mult_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the multiplier scheduler: word width,
// response entry layout and a constant-foldable clog2.
package approx_mult_pkg;

  localparam int FP_W     = 32;
  // Widest tag the scheduler supports (N_REQ up to 8).
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [FP_W-1:0]     data;
  } rsp_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_mult.sv
// Approximate single-precision multiplier core with a registered output.
// Denormal inputs flush to signed zero, any exponent-255 input yields
// signed infinity, and the mantissa is truncated with a jam (sticky OR)
// into the LSB instead of round-to-nearest.
module approx_mult
  import approx_mult_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] p_o
);

  logic            sign;
  logic [7:0]      ea;
  logic [7:0]      eb;
  logic [47:0]     m_prod;
  logic [9:0]      e_sum;
  logic [9:0]      e_res;
  logic [22:0]     frac;
  logic            jam;
  logic [FP_W-1:0] p_d;
  logic [FP_W-1:0] p_q;

  // Product datapath: special cases first, then normalise and truncate.
  always_comb begin
    sign   = a_i[31] ^ b_i[31];
    ea     = a_i[30:23];
    eb     = b_i[30:23];
    m_prod = {24'b0, 1'b1, a_i[22:0]} * {24'b0, 1'b1, b_i[22:0]};
    e_sum  = {2'b0, ea} + {2'b0, eb} + {9'b0, m_prod[47]};
    e_res  = e_sum - 10'd127;
    frac   = m_prod[47] ? m_prod[46:24] : m_prod[45:23];
    jam    = m_prod[47] ? |m_prod[23:0] : |m_prod[22:0];
    if (ea == 8'hFF || eb == 8'hFF) begin
      p_d = {sign, 8'hFF, 23'h0};
    end else if (ea == 8'h00 || eb == 8'h00) begin
      p_d = {sign, 31'h0};
    end else if (e_sum <= 10'd127) begin
      p_d = {sign, 31'h0};
    end else if (e_res >= 10'd255) begin
      p_d = {sign, 8'hFF, 23'h0};
    end else begin
      p_d = {sign, e_res[7:0], frac | {22'b0, jam}};
    end
  end

  // Output register of the core.
  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p_o = p_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after
// ptr_i (wrapping) wins. The grant is suppressed when en_i is low, but
// the winner index is still reported.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o
);

  logic            found;
  logic [ID_W:0]   cand;

  // Circular search starting at the pointer.
  always_comb begin
    found       = 1'b0;
    cand        = '0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req_i[cand[ID_W-1:0]]) begin
        found       = 1'b1;
        grant_idx_o = cand[ID_W-1:0];
      end
    end
    if (en_i && found) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/approx_mult_sched.sv
// Shares one approx_mult core among N_REQ requesters. Issue is gated so
// that everything in flight always has a reserved response-FIFO slot,
// which makes it safe to stall the consumer indefinitely.
module approx_mult_sched
  import approx_mult_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FP_W-1:0]       rsp_data,
  output logic                  busy
);

  localparam int PTR_W = clog2(RSP_DEPTH);
  localparam int OCC_W = PTR_W + 2;

  logic [FP_W-1:0]  a_lane [N_REQ];
  logic [FP_W-1:0]  b_lane [N_REQ];

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             hs;
  logic             issue_ok;
  logic [OCC_W-1:0] occ;

  logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]  s1_id_q,    s1_id_d;
  logic [FP_W-1:0]  op_a_q,     op_a_d;
  logic [FP_W-1:0]  op_b_q,     op_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]  s2_id_q,    s2_id_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W:0]   count_q,    count_d;

  logic [FP_W-1:0]  core_p;
  logic             push;
  logic             pop;
  rsp_entry_t       wr_entry;
  rsp_entry_t       head;
  rsp_entry_t       mem [RSP_DEPTH];

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign a_lane[gi] = req_a[FP_W*gi +: FP_W];
    assign b_lane[gi] = req_b[FP_W*gi +: FP_W];
  end

  assign occ      = OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q) + OCC_W'(count_q);
  assign issue_ok = occ < OCC_W'(RSP_DEPTH);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (issue_ok & ~rst),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // A grant only ever goes to an asserted requester, so any grant is a handshake.
  assign req_ready = grant;
  assign hs        = |grant;

  approx_mult u_core (
    .clk (clk),
    .rst (rst),
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (core_p)
  );

  assign push      = s2_valid_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign head      = mem[rd_ptr_q];
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_id    = rsp_valid ? ID_W'(head.id) : '0;
  assign busy      = (occ != '0);

  // Next-state for pointer, pipeline tags and FIFO bookkeeping.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    if (hs) rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    s1_valid_d = hs;
    s1_id_d    = hs ? grant_idx : s1_id_q;
    op_a_d     = hs ? a_lane[grant_idx] : op_a_q;
    op_b_d     = hs ? b_lane[grant_idx] : op_b_q;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    wr_entry      = '0;
    wr_entry.id   = MAX_ID_W'(s2_id_q);
    wr_entry.data = core_p;
  end

  // Control and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Response storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_approx_mult_sched.sv
// Self-checking bench for approx_mult_sched: random requesters against a
// scoreboard of expected {id, product, earliest-visible cycle} entries.
module tb_approx_mult_sched;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_data;
  logic           busy;

  logic [31:0]    a_arr [N];
  logic [31:0]    b_arr [N];

  approx_mult_sched #(.N_REQ(N), .ID_W(2), .RSP_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_arr[i];
      req_b[32*i +: 32] = b_arr[i];
    end
  end

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference for the core: real-number style multiply on the
  // 24-bit significands, truncated with a sticky LSB.
  function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    longint unsigned p, frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0)     return {s, 31'h0};
    p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    if (e <= 0)   return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    frac = (p >> sh) & 64'h7FFFFF;
    if ((p % (64'd1 << sh)) != 0) frac = frac | 64'd1;
    return {s, 8'(e), 23'(frac)};
  endfunction

  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0] e;
    r = int'($urandom_range(9));
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else if (r < 4)  e = 8'($urandom_range(1, 254));
    else             e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(1)), e, 23'($urandom)};
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          ready_at;
  } exp_t;

  exp_t     sb [$];
  int       cyc = 0;
  bit       model_ok = 0;
  int       rr_m = 0;
  int       pop_cnt = 0;
  logic [N-1:0] fired = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare outputs with the model state, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    bit exp_rv;
    exp_rv    = 0;
    exp_ready = '0;
    if (model_ok) begin
      exp_rv = (sb.size() > 0) && (sb[0].ready_at <= cyc);
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("busy", 64'(busy), 64'(sb.size() != 0));
      if (exp_rv && rsp_valid) begin
        check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
      end
      if (!rst && sb.size() < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (rr_m + k) % N;
          if (req_valid[idx]) begin
            exp_ready[idx] = 1'b1;
            break;
          end
        end
      end
    end
    if (model_ok || rst) check("req_ready", 64'(req_ready), 64'(exp_ready));

    fired = req_valid & req_ready & {N{~rst}};
    if (rst) begin
      sb.delete();
      rr_m     = 0;
      model_ok = 1;
    end else if (model_ok) begin
      if (exp_rv && rsp_ready) begin
        void'(sb.pop_front());
        pop_cnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          exp_t e;
          e.id       = 2'(i);
          e.data     = ref_mult(a_arr[i], b_arr[i]);
          e.ready_at = cyc + 3;
          sb.push_back(e);
          rr_m = (i + 1) % N;
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [N-1:0] en_mask = '0;
  int vprob   = 0;
  int rsp_mode = 1;   // 0 low, 1 high, 2 toggle, 3 hold, 4 random

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && en_mask[i] && int'($urandom_range(99)) < vprob) begin
        req_valid[i] = 1'b1;
        a_arr[i]     = rand_fp();
        b_arr[i]     = rand_fp();
      end
    end
    case (rsp_mode)
      0: rsp_ready = 1'b0;
      1: rsp_ready = 1'b1;
      2: rsp_ready = ~rsp_ready;
      4: rsp_ready = 1'($urandom_range(1));
      default: ;
    endcase
  endtask

  task automatic drain(input string tag);
    bit done;
    done     = 0;
    en_mask  = '0;
    rsp_mode = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy && req_valid == '0) begin
        done = 1;
        break;
      end
      step();
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    int hs_cyc, acc, acc2, pops, base, id2_seen;
    bit got;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    en_mask   = '1;
    vprob     = 100;
    rsp_mode  = 1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = rand_fp();
      b_arr[i] = rand_fp();
    end

    // Reset held for two edges with all requesters valid.
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;

    // Round-robin order with all four requesters continuously valid.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check("first_ready", 64'(req_ready), 64'b0001);
      check("rr_grant", 64'(onehot_idx(req_ready)), 64'(k % N));
      step();
    end
    drain("drain_rr");

    // Single request: 0.0 * 3.0 from requester 2.
    step();
    req_valid[2] = 1'b1;
    a_arr[2]     = 32'h0000_0000;
    b_arr[2]     = 32'h4040_0000;
    hs_cyc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_valid[2] && req_ready[2]) begin
        hs_cyc = cyc;
        break;
      end
      step();
    end
    check("single_hs", 64'(hs_cyc >= 0), 64'd1);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        check("single_lat", 64'(cyc - hs_cyc), 64'd3);
        check("single_id", 64'(rsp_id), 64'd2);
        check("single_data", 64'(rsp_data), 64'h0);
        break;
      end
    end
    check("single_rsp", 64'(got), 64'd1);
    drain("drain_single");

    // Backpressure: exactly DEPTH accepts, then one pop frees exactly one slot.
    step();
    en_mask   = 4'b0011;
    vprob     = 100;
    rsp_mode  = 0;
    rsp_ready = 1'b0;
    acc = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) acc++;
      step();
    end
    check("bp_accepts", 64'(acc), 64'(DEPTH));
    @(negedge clk);
    check("bp_stalled", 64'(req_ready), 64'd0);
    rsp_mode = 3;
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    pops = (rsp_valid && rsp_ready) ? 1 : 0;
    check("bp_still_full", 64'(req_ready), 64'd0);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    acc2 = ((req_valid & req_ready) != '0) ? 1 : 0;
    check("bp_reissue", 64'(acc2), 64'd1);
    step();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) acc2++;
      step();
    end
    check("bp_pops", 64'(pops), 64'd1);
    check("bp_one_more", 64'(acc2), 64'd1);
    drain("drain_bp");

    // Streaming with rsp_ready toggling every cycle, 32 results.
    step();
    base     = pop_cnt;
    en_mask  = '1;
    vprob    = 70;
    rsp_mode = 2;
    for (int n = 0; n < 600; n++) begin
      step();
      @(negedge clk);
      if (pop_cnt - base >= 32) break;
    end
    check("stream_32", 64'(pop_cnt - base >= 32), 64'd1);
    drain("drain_stream");
    check("stream_sb_empty", 64'(sb.size()), 64'd0);
    check("stream_busy", 64'(busy), 64'd0);

    // Reset with three results in flight/buffered from requester 2.
    step();
    en_mask   = 4'b0100;
    vprob     = 100;
    rsp_mode  = 0;
    rsp_ready = 1'b0;
    acc = 0;
    for (int n = 0; n < 30 && acc < 3; n++) begin
      @(negedge clk);
      if (req_valid[2] && req_ready[2]) acc++;
      if (acc == 3) en_mask = '0;
      step();
    end
    check("mid_accepts", 64'(acc), 64'd3);
    rst          = 1'b1;
    req_valid[1] = 1'b1;
    a_arr[1]     = rand_fp();
    b_arr[1]     = rand_fp();
    req_valid[3] = 1'b1;
    a_arr[3]     = rand_fp();
    b_arr[3]     = rand_fp();
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_rearb", 64'(req_ready), 64'b0010);
    rsp_mode = 1;
    id2_seen = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      @(negedge clk);
      if (rsp_valid && rsp_id == 2'd2) id2_seen++;
    end
    check("mid_discarded", 64'(id2_seen), 64'd0);
    drain("drain_mid");

    // Mixed random traffic with random backpressure.
    step();
    en_mask  = '1;
    vprob    = 50;
    rsp_mode = 4;
    for (int n = 0; n < 300; n++) step();
    drain("drain_rand");
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
